// File: rtl/cim_core_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cim_core_mem_arb_pkg
// Brief   : Shared constants and read-tracking type for the CIM memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package cim_core_mem_arb_pkg;

  localparam int MAX_RD_LATENCY = 4;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rd_track_t;

endpackage
`default_nettype wire

// File: rtl/cim_core_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : cim_core_rr_arb
// Brief   : Round-robin grant generator; search starts at i_ptr and wraps.
// Revision: 1.0 - initial release
// ============================================================================
module cim_core_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any_gnt
);

  int w_cand;

  always_comb begin
    o_gnt     = '0;
    o_idx     = '0;
    o_any_gnt = 1'b0;
    w_cand    = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_cand = (int'(i_ptr) + off) % NUM_PORTS;
      if (!o_any_gnt && i_req[w_cand]) begin
        o_any_gnt     = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = IDX_W'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cim_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cim_core_mem_arbiter
// Brief   : Round-robin N:1 memory request arbiter with read-response routing.
// Revision: 1.0 - initial release
// ============================================================================
module cim_core_mem_arbiter
  import cim_core_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int RD_LATENCY     = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS*MEM_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*MEM_DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*MEM_DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [NUM_PORTS*MEM_DATA_WIDTH-1:0]   rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [MEM_DATA_WIDTH/8-1:0]           mem_be_o,
  output logic [MEM_DATA_WIDTH-1:0]             mem_data_o,
  input  logic [MEM_DATA_WIDTH-1:0]             mem_data_i
);

  localparam int c_idx_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_be_w  = MEM_DATA_WIDTH / 8;
  localparam int c_depth = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                           ((RD_LATENCY < 1) ? 1 : RD_LATENCY);

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [c_idx_w-1:0]   w_idx;
  logic [c_idx_w-1:0]   r_ptr;
  logic                 w_any;
  rd_track_t            w_push;
  rd_track_t            w_head;
  rd_track_t            r_rd_pipe [c_depth];

  // Masking requests during reset keeps every downstream output quiet.
  assign w_req = rst_i ? '0 : req_i;

  cim_core_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (c_idx_w)
  ) u_rr_arb (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_idx     (w_idx),
    .o_any_gnt (w_any)
  );

  assign gnt_o = w_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (int'(w_idx) == NUM_PORTS - 1) ? '0 : w_idx + 1'b1;
    end
  end

  always_comb begin
    mem_req_o  = w_any;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_be_o   = '0;
    mem_data_o = '0;
    if (w_any) begin
      mem_we_o   = we_i[w_idx];
      mem_addr_o = addr_i[int'(w_idx)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      mem_be_o   = be_i[int'(w_idx)*c_be_w +: c_be_w];
      mem_data_o = wdata_i[int'(w_idx)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end
  end

  always_comb begin
    w_push       = '0;
    w_push.valid = w_any & ~we_i[w_idx];
    w_push.idx   = 3'(w_idx);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < c_depth; i++) begin
        r_rd_pipe[i] <= '0;
      end
    end else begin
      r_rd_pipe[0] <= w_push;
      for (int i = 1; i < c_depth; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  assign w_head = r_rd_pipe[c_depth-1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_resp
    assign rvalid_o[p] = w_head.valid && (w_head.idx == 3'(p));
    assign rdata_o[p*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] =
      rvalid_o[p] ? mem_data_i : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_cim_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cim_core_mem_arbiter
// Brief   : Directed self-checking bench; latency-1 and latency-3 instances.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cim_core_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: RD_LATENCY = 1
  logic         rst_a;
  logic [3:0]   req_a, we_a, gnt_a, rvalid_a;
  logic [127:0] addr_a;
  logic [31:0]  be_a;
  logic [255:0] wdata_a, rdata_a;
  logic         mreq_a, mwe_a;
  logic [31:0]  maddr_a;
  logic [7:0]   mbe_a;
  logic [63:0]  mdo_a, mdi_a;

  // Instance B: RD_LATENCY = 3
  logic         rst_b;
  logic [3:0]   req_b, we_b, gnt_b, rvalid_b;
  logic [127:0] addr_b;
  logic [31:0]  be_b;
  logic [255:0] wdata_b, rdata_b;
  logic         mreq_b, mwe_b;
  logic [31:0]  maddr_b;
  logic [7:0]   mbe_b;
  logic [63:0]  mdo_b, mdi_b;

  cim_core_mem_arbiter #(
    .NUM_PORTS(4), .MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(64), .RD_LATENCY(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .be_i(be_a), .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .mem_req_o(mreq_a), .mem_we_o(mwe_a),
    .mem_addr_o(maddr_a), .mem_be_o(mbe_a), .mem_data_o(mdo_a),
    .mem_data_i(mdi_a)
  );

  cim_core_mem_arbiter #(
    .NUM_PORTS(4), .MEM_ADDR_WIDTH(32), .MEM_DATA_WIDTH(64), .RD_LATENCY(3)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .be_i(be_b), .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .mem_req_o(mreq_b), .mem_we_o(mwe_b),
    .mem_addr_o(maddr_b), .mem_be_o(mbe_b), .mem_data_o(mdo_b),
    .mem_data_i(mdi_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive just after the rising edge, observe on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1; req_a = 4'hF; we_a = 4'hF; addr_a = '0; be_a = '0;
    wdata_a = '0; mdi_a = '0;
    rst_b = 1'b1; req_b = '0; we_b = '0; addr_b = '0; be_b = '0;
    wdata_b = '0; mdi_b = '0;
    for (int p = 0; p < 4; p++) addr_a[p*32 +: 32] = 32'h1000 + 32'(4*p);

    sample();
    check("rst_gnt", 64'(gnt_a), 64'h0);
    check("rst_mem_req", 64'(mreq_a), 64'h0);
    check("rst_mem_we", 64'(mwe_a), 64'h0);
    check("rst_rvalid", 64'(rvalid_a), 64'h0);

    step();
    rst_a = 1'b0;
    we_a  = 4'h0;

    // All ports reading continuously: strict rotation 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      req_a = 4'hF;
      mdi_a = 64'h5000 + 64'(i);
      sample();
      check($sformatf("rr_gnt_%0d", i), 64'(gnt_a), 64'(4'b0001 << (i % 4)));
      check($sformatf("rr_mreq_%0d", i), 64'(mreq_a), 64'h1);
      check($sformatf("rr_addr_%0d", i), 64'(maddr_a), 64'h1000 + 64'(4*(i % 4)));
      if (i > 0) begin
        check($sformatf("rr_rvalid_%0d", i), 64'(rvalid_a), 64'(4'b0001 << ((i-1) % 4)));
        check($sformatf("rr_rdata_%0d", i), rdata_a[((i-1)%4)*64 +: 64], 64'h5000 + 64'(i));
      end
    end

    step();
    req_a = 4'h0; mdi_a = 64'h5008;
    sample();
    check("idle_gnt", 64'(gnt_a), 64'h0);
    check("idle_mreq", 64'(mreq_a), 64'h0);
    check("idle_addr", 64'(maddr_a), 64'h0);
    check("idle_rvalid", 64'(rvalid_a), 64'h8);
    check("idle_rdata3", rdata_a[3*64 +: 64], 64'h5008);

    // Port 2 single read at 0x40
    step();
    req_a = 4'b0100; addr_a[2*32 +: 32] = 32'h40;
    sample();
    check("rd2_gnt", 64'(gnt_a), 64'h4);
    check("rd2_addr", 64'(maddr_a), 64'h40);
    check("rd2_we", 64'(mwe_a), 64'h0);
    step();
    req_a = 4'h0; mdi_a = 64'hDEAD_BEEF;
    sample();
    check("rd2_rvalid", 64'(rvalid_a), 64'h4);
    check("rd2_rdata", rdata_a[2*64 +: 64], 64'hDEAD_BEEF);
    check("rd2_lane0", rdata_a[0 +: 64], 64'h0);

    // Port 1 write: forwarded fields, never a response
    step();
    req_a = 4'b0010; we_a = 4'b0010;
    be_a[1*8 +: 8] = 8'h0F; wdata_a[1*64 +: 64] = 64'h1234;
    sample();
    check("wr1_gnt", 64'(gnt_a), 64'h2);
    check("wr1_we", 64'(mwe_a), 64'h1);
    check("wr1_be", 64'(mbe_a), 64'h0F);
    check("wr1_data", 64'(mdo_a), 64'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      req_a = 4'h0; we_a = 4'h0;
      sample();
      check($sformatf("wr1_norvalid_%0d", i), 64'(rvalid_a), 64'h0);
    end

    // Pointer now 2: port 3 alone, then ports 0 and 3 -> wraps to port 0
    step();
    req_a = 4'b1000;
    sample();
    check("wrap_gnt3", 64'(gnt_a), 64'h8);
    step();
    req_a = 4'b1001;
    sample();
    check("wrap_gnt0", 64'(gnt_a), 64'h1);
    step();
    req_a = 4'h0;

    // Latency-3 instance: reads from port 3 then port 0
    rst_b = 1'b0;
    step();
    req_b = 4'b1000;
    sample();
    check("l3_gnt3", 64'(gnt_b), 64'h8);
    step();
    req_b = 4'b0001;
    sample();
    check("l3_gnt0", 64'(gnt_b), 64'h1);
    check("l3_rvalid_t1", 64'(rvalid_b), 64'h0);
    step();
    req_b = 4'h0;
    sample();
    check("l3_rvalid_t2", 64'(rvalid_b), 64'h0);
    step();
    mdi_b = 64'hAAAA;
    sample();
    check("l3_rvalid_t3", 64'(rvalid_b), 64'h8);
    check("l3_rdata3", rdata_b[3*64 +: 64], 64'hAAAA);
    step();
    mdi_b = 64'hBBBB;
    sample();
    check("l3_rvalid_t4", 64'(rvalid_b), 64'h1);
    check("l3_rdata0", rdata_b[0 +: 64], 64'hBBBB);
    check("l3_rdata3_clr", rdata_b[3*64 +: 64], 64'h0);
    step();
    sample();
    check("l3_rvalid_t5", 64'(rvalid_b), 64'h0);

    // Read to port 1 cut off by a reset pulse one cycle later
    step();
    req_b = 4'b0010;
    sample();
    check("rst_rd_gnt1", 64'(gnt_b), 64'h2);
    step();
    req_b = 4'h0; rst_b = 1'b1;
    sample();
    check("rst_pulse_rvalid", 64'(rvalid_b), 64'h0);
    step();
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      sample();
      check($sformatf("rst_norvalid_%0d", i), 64'(rvalid_b), 64'h0);
    end
    step();
    req_b = 4'hF;
    sample();
    check("rst_ptr0_gnt", 64'(gnt_b), 64'h1);
    step();
    req_b = 4'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cim_core_mem_arbiter.md
# cim_core_mem_arbiter

Round-robin N:1 memory-request arbiter that merges several initiators onto the single CIM_CORE memory port that feeds the macro address demux. It grants one request per cycle and forwards it downstream combinationally. It tracks every granted read through a latency pipeline so that returning read data reaches the initiator that issued it. It sits between the CIM core's request sources (DMA, controller, host bridge) and the macro-side demux.

## Interface
Parameters:
- NUM_PORTS, 4: number of initiators, 2..8.
- MEM_ADDR_WIDTH, 32: address width.
- MEM_DATA_WIDTH, 64: data width, a multiple of 8.
- RD_LATENCY, 1: cycles from downstream read request to valid mem_data_i, 1..4.

Ports (clock and reset first):
- clk_i  in  1  clock. One clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  per-port request. Held until granted.
- we_i  in  NUM_PORTS  per-port write enable.
- addr_i  in  NUM_PORTS×MEM_ADDR_WIDTH  per-port address.
- be_i  in  NUM_PORTS×MEM_DATA_WIDTH/8  per-port byte enables.
- wdata_i  in  NUM_PORTS×MEM_DATA_WIDTH  per-port write data.
- gnt_o  out  NUM_PORTS  one-hot grant, same cycle as the request.
- rvalid_o  out  NUM_PORTS  one-hot read-response valid.
- rdata_o  out  NUM_PORTS×MEM_DATA_WIDTH  per-port read data.
- mem_req_o  out  1  downstream request.
- mem_we_o  out  1  downstream write enable.
- mem_addr_o  out  MEM_ADDR_WIDTH  downstream address.
- mem_be_o  out  MEM_DATA_WIDTH/8  downstream byte enables.
- mem_data_o  out  MEM_DATA_WIDTH  downstream write data.
- mem_data_i  in  MEM_DATA_WIDTH  downstream read data.

## Operation
- The downstream port is always ready: every cycle with mem_req_o=1 is accepted.
- Arbitration:
  - Priority pointer ptr_q has width IDX_W = max(1, $clog2(NUM_PORTS)).
  - Search req_i starting at ptr_q, upward, wrapping modulo NUM_PORTS. The first set bit wins.
- Grant cycle:
  - gnt_o[w]=1 and mem_req_o=1.
  - mem_we_o, mem_addr_o, mem_be_o and mem_data_o carry port w's fields.
  - Next cycle, ptr_q = (w+1) mod NUM_PORTS. When w = NUM_PORTS-1, ptr_q wraps to 0.
- No request: gnt_o=0, mem_req_o=0, all mem_* outputs 0, ptr_q holds.
- Read tracking:
  - A granted read (we_i=0) pushes {valid=1, idx=w} into a RD_LATENCY-deep shift pipeline.
  - A write or an idle cycle pushes valid=0.
  - At the pipeline head with valid=1: rvalid_o[idx]=1 and rdata_o[idx]=mem_data_i.
  - All other rdata_o lanes are 0. Writes never produce rvalid.
- Back-to-back reads: one read per cycle from any mix of ports. Responses return in issue order, one per cycle.
- Initiators are expected to hold req_i and all fields stable until granted. Dropping req_i before grant withdraws the request without error.

## Timing
- Grant is combinational: request in cycle T, gnt_o and mem_req_o in cycle T.
- A read granted in cycle T gets rvalid_o in cycle T+RD_LATENCY.
- The read-response path is combinational from mem_data_i to rdata_o.
- Reset values:
  - ptr_q=0 and all pipeline valid bits 0.
  - While rst_i=1, gnt_o, mem_req_o, mem_we_o and rvalid_o are forced to 0, regardless of req_i.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid_o after reset releases.
- Request and response in the same cycle: a new grant and an older read's rvalid_o may coincide, including on the same port. Both are honoured.
- Single requester: it is granted every cycle, with no bubbles.

## Structure
- Package cim_core_mem_arb_pkg holds:
  - localparam MAX_RD_LATENCY = 4.
  - typedef rd_track_t, a packed struct {logic valid; logic [2:0] idx;}.
- Sub-module cim_core_rr_arb: pure round-robin grant generator.
  - Inputs: req vector, ptr.
  - Outputs: one-hot gnt, winner index, any_gnt.
- The pointer register, the downstream mux and the response pipeline stay in the top module.

## Test plan
- Port 2 reads addr 0x40 with RD_LATENCY=1, memory returning 0xDEAD_BEEF → gnt_o=4'b0100 in T, mem_addr_o=0x40, mem_we_o=0; rvalid_o=4'b0100 and rdata_o[2]=0xDEAD_BEEF in T+1.
- All 4 ports request continuously for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3, with mem_req_o=1 every cycle.
- Port 1 writes be=0x0F, data 0x1234 → mem_we_o=1, mem_be_o=0x0F, mem_data_o=0x1234; no rvalid_o in any later cycle.
- RD_LATENCY=3, reads port 3 then port 0 in consecutive cycles T, T+1 → rvalid_o[3] at T+3 and rvalid_o[0] at T+4, each carrying that cycle's mem_data_i.
- Read granted to port 1, then rst_i pulsed one cycle later → no rvalid_o ever; first post-reset grant comes from ptr_q=0.
- Only port 3 requests, then ports 0 and 3 request together → port 3 granted, ptr_q wraps to 0, port 0 granted next.
